// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcodes, control encodings and main-decode table for the RV32I control unit
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    aluop_e     alu_op;
    logic       jump;
  } main_ctrl_t;

  // Unknown opcodes fall through to the all-zero NOP so nothing is written or redirected.
  function automatic main_ctrl_t main_decode(input logic [6:0] op);
    main_ctrl_t c;
    c = '0;
    case (op)
      OP_LOAD: begin
        c.reg_write  = 1'b1;
        c.imm_src    = IMM_I;
        c.alu_src    = 1'b1;
        c.result_src = RES_MEM;
        c.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        c.imm_src   = IMM_S;
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      OP_R: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      OP_IMM: begin
        c.reg_write = 1'b1;
        c.imm_src   = IMM_I;
        c.alu_src   = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        c.imm_src = IMM_B;
        c.branch  = 1'b1;
        c.alu_op  = ALUOP_SUB;
      end
      OP_JAL: begin
        c.reg_write  = 1'b1;
        c.imm_src    = IMM_J;
        c.result_src = RES_PC4;
        c.jump       = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv_alu_decoder.sv
// rtl/rv_alu_decoder.sv - combinational ALUOp/funct3/funct7 to ALU operation decode
module rv_alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // op5 separates R-type from I-ALU: addi has no subtract form even with bit30 set.
          3'b000:  alu_ctrl_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b111:  alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_control_unit.sv
// rtl/rv_control_unit.sv - RV32I main control decoder with a registered output stage
module rv_control_unit
  import rv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic        Pcsrc,
  output logic [1:0]  ResultSrc,
  output logic        Alusrc,
  output logic [2:0]  Aluctrl,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ImmSrc,
  output logic        regwire,
  output logic        memwrite
);

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_instr_bits;

  assign op       = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7b5 = instruction[30];
  assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

  main_ctrl_t ctrl_d;
  logic [2:0] aluctrl_d;

  assign ctrl_d = main_decode(op);

  rv_alu_decoder u_alu_decoder (
    .alu_op_i   (ctrl_d.alu_op),
    .funct3_i   (funct3),
    .op5_i      (op[5]),
    .funct7b5_i (funct7b5),
    .alu_ctrl_o (aluctrl_d)
  );

  logic       pcsrc_d;
  logic       pcsrc_q;
  logic [1:0] result_src_q;
  logic       alu_src_q;
  logic [2:0] aluctrl_q;
  logic [1:0] alu_op_q;
  logic [1:0] imm_src_q;
  logic       reg_write_q;
  logic       mem_write_q;

  // Branch qualification with Zero happens in the datapath; here it is only a request.
  assign pcsrc_d = ctrl_d.branch | ctrl_d.jump;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcsrc_q      <= 1'b0;
      result_src_q <= 2'b00;
      alu_src_q    <= 1'b0;
      aluctrl_q    <= 3'b000;
      alu_op_q     <= 2'b00;
      imm_src_q    <= 2'b00;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      pcsrc_q      <= pcsrc_d;
      result_src_q <= ctrl_d.result_src;
      alu_src_q    <= ctrl_d.alu_src;
      aluctrl_q    <= aluctrl_d;
      alu_op_q     <= ctrl_d.alu_op;
      imm_src_q    <= ctrl_d.imm_src;
      reg_write_q  <= ctrl_d.reg_write;
      mem_write_q  <= ctrl_d.mem_write;
    end
  end

  assign Pcsrc     = pcsrc_q;
  assign ResultSrc = result_src_q;
  assign Alusrc    = alu_src_q;
  assign Aluctrl   = aluctrl_q;
  assign ALUOp     = alu_op_q;
  assign ImmSrc    = imm_src_q;
  assign regwire   = reg_write_q;
  assign memwrite  = mem_write_q;

endmodule

// File: tb/tb_rv_control_unit.sv
// tb/tb_rv_control_unit.sv - directed-vector self-checking bench for rv_control_unit
module tb_rv_control_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        Pcsrc;
  logic [1:0]  ResultSrc;
  logic        Alusrc;
  logic [2:0]  Aluctrl;
  logic [1:0]  ALUOp;
  logic [1:0]  ImmSrc;
  logic        regwire;
  logic        memwrite;

  int n_checks;
  int n_passed;

  rv_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .Pcsrc       (Pcsrc),
    .ResultSrc   (ResultSrc),
    .Alusrc      (Alusrc),
    .Aluctrl     (Aluctrl),
    .ALUOp       (ALUOp),
    .ImmSrc      (ImmSrc),
    .regwire     (regwire),
    .memwrite    (memwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {Pcsrc, ResultSrc, Alusrc, Aluctrl, ALUOp, ImmSrc, regwire, memwrite}
  function automatic logic [12:0] outs();
    return {Pcsrc, ResultSrc, Alusrc, Aluctrl, ALUOp, ImmSrc, regwire, memwrite};
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic step(input string tag, input logic [31:0] instr, input logic [12:0] exp);
    @(negedge clk);
    instruction = instr;
    @(posedge clk);
    #1;
    check(tag, outs(), exp);
  endtask

  localparam logic [12:0] E_NOP  = 13'b0_00_0_000_00_00_0_0;
  localparam logic [12:0] E_LW   = 13'b0_01_1_000_00_00_1_0;
  localparam logic [12:0] E_SW   = 13'b0_00_1_000_00_01_0_1;
  localparam logic [12:0] E_ADD  = 13'b0_00_0_000_10_00_1_0;
  localparam logic [12:0] E_SUB  = 13'b0_00_0_001_10_00_1_0;
  localparam logic [12:0] E_AND  = 13'b0_00_0_010_10_00_1_0;
  localparam logic [12:0] E_OR   = 13'b0_00_0_011_10_00_1_0;
  localparam logic [12:0] E_SLT  = 13'b0_00_0_101_10_00_1_0;
  localparam logic [12:0] E_ADDI = 13'b0_00_1_000_10_00_1_0;
  localparam logic [12:0] E_ANDI = 13'b0_00_1_010_10_00_1_0;
  localparam logic [12:0] E_ORI  = 13'b0_00_1_011_10_00_1_0;
  localparam logic [12:0] E_SLTI = 13'b0_00_1_101_10_00_1_0;
  localparam logic [12:0] E_BEQ  = 13'b1_00_0_001_01_10_0_0;
  localparam logic [12:0] E_JAL  = 13'b1_10_0_000_00_11_1_0;

  initial begin
    n_checks    = 0;
    n_passed    = 0;
    rst         = 1'b1;
    instruction = 32'h0000_2083;

    repeat (2) @(posedge clk);
    #1;
    check("reset_nop", outs(), E_NOP);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("lw_after_reset", outs(), E_LW);

    // New instruction must not show up before the next edge.
    @(negedge clk);
    instruction = 32'h0010_2023;
    #1;
    check("latency_hold", outs(), E_LW);
    @(posedge clk);
    #1;
    check("sw", outs(), E_SW);

    step("add",        32'h0020_81B3, E_ADD);
    step("sub",        32'h4020_81B3, E_SUB);
    step("and",        32'h0020_F1B3, E_AND);
    step("or",         32'h0020_E1B3, E_OR);
    step("slt",        32'h0020_A1B3, E_SLT);
    step("r_funct3_1", 32'h0020_91B3, E_ADD);
    step("addi_b30",   32'h4000_8093, E_ADDI);
    step("andi",       32'h0000_F093, E_ANDI);
    step("ori",        32'h0000_E093, E_ORI);
    step("slti",       32'h0000_A093, E_SLTI);
    step("beq",        32'h0000_0063, E_BEQ);
    step("beq_b30",    32'h4000_0063, E_BEQ);
    step("jal",        32'h0000_006F, E_JAL);
    step("illegal_1b", 32'h0000_001B, E_NOP);
    step("lw_again",   32'h0000_2083, E_LW);
    step("all_zero",   32'h0000_0000, E_NOP);
    step("jal_hold",   32'h0000_006F, E_JAL);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_jal", outs(), E_NOP);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("jal_after_release", outs(), E_JAL);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
